// File: rtl/audio_pkg.sv
// Shared constants for the voice allocator and the oscillator/envelope top.
// The voice_key bus packs one KEYW-bit key index per voice, voice 0 in the LSBs.
package audio_pkg;

    localparam int unsigned NVOICES_DEF = 4;
    localparam int unsigned NKEYS_DEF   = 8;
    localparam int unsigned KEYW        = 3;
    localparam int unsigned AGEW        = 3;
    localparam int unsigned CNTW        = 4;

    function automatic int unsigned vk_lsb(input int unsigned v);
        return v * KEYW;
    endfunction

endpackage

// File: rtl/lowest_set.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 in vec, valid if any bit is set.
module lowest_set #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (vec[i] && !valid) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: services one key event per cycle (lowest key first),
// assigning presses to a matching idle voice, the lowest idle voice, or stealing the oldest.
module voice_allocator
    import audio_pkg::*;
#(
    parameter int unsigned NVOICES = NVOICES_DEF,
    parameter int unsigned NKEYS   = NKEYS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NKEYS-1:0]         key,
    output logic [NVOICES-1:0]       voice_gate,
    output logic [NVOICES*KEYW-1:0]  voice_key,
    output logic [NVOICES-1:0]       voice_retrig,
    output logic [CNTW-1:0]          voice_count,
    output logic                     steal
);

    logic [NKEYS-1:0]   key_state_q, key_state_d;
    logic [NVOICES-1:0] gate_q, gate_d;
    logic [NVOICES-1:0] retrig_q, retrig_d;
    logic [KEYW-1:0]    vkey_q [NVOICES];
    logic [KEYW-1:0]    vkey_d [NVOICES];
    logic [AGEW-1:0]    age_q  [NVOICES];
    logic [AGEW-1:0]    age_d  [NVOICES];
    logic [CNTW-1:0]    count_q, count_d;
    logic               steal_q, steal_d;

    logic [NKEYS-1:0]   ev;
    logic [KEYW-1:0]    ev_idx;
    logic               ev_valid;
    logic               ev_press;
    logic [NVOICES-1:0] match_free;
    logic [KEYW-1:0]    match_idx, free_idx, old_idx, sel_idx;
    logic               match_valid, free_valid;
    logic [AGEW-1:0]    sel_age;

    assign ev = key ^ key_state_q;

    lowest_set #(.W(NKEYS),   .IW(KEYW)) u_ev    (.vec(ev),         .idx(ev_idx),    .valid(ev_valid));
    lowest_set #(.W(NVOICES), .IW(KEYW)) u_match (.vec(match_free), .idx(match_idx), .valid(match_valid));
    lowest_set #(.W(NVOICES), .IW(KEYW)) u_free  (.vec(~gate_q),    .idx(free_idx),  .valid(free_valid));

    always_comb begin
        match_free = '0;
        for (int unsigned v = 0; v < NVOICES; v++) begin
            match_free[v] = !gate_q[v] && (vkey_q[v] == ev_idx);
        end
    end

    always_comb begin
        ev_press = 1'b0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (KEYW'(i) == ev_idx) ev_press = key[i];
        end
        old_idx = '0;
        for (int unsigned v = 0; v < NVOICES; v++) begin
            if (age_q[v] == AGEW'(NVOICES - 1)) old_idx = KEYW'(v);
        end
    end

    always_comb begin
        sel_idx = match_valid ? match_idx : (free_valid ? free_idx : old_idx);
        sel_age = '0;
        for (int unsigned v = 0; v < NVOICES; v++) begin
            if (KEYW'(v) == sel_idx) sel_age = age_q[v];
        end
    end

    always_comb begin
        key_state_d = key_state_q;
        gate_d      = gate_q;
        vkey_d      = vkey_q;
        age_d       = age_q;
        retrig_d    = '0;
        steal_d     = 1'b0;
        if (ev_valid) begin
            for (int unsigned i = 0; i < NKEYS; i++) begin
                if (KEYW'(i) == ev_idx) key_state_d[i] = ev_press;
            end
            if (ev_press) begin
                // Allocated voice becomes youngest; only voices younger than it age by one.
                for (int unsigned v = 0; v < NVOICES; v++) begin
                    if (KEYW'(v) == sel_idx) begin
                        gate_d[v]   = 1'b1;
                        vkey_d[v]   = ev_idx;
                        retrig_d[v] = 1'b1;
                        age_d[v]    = '0;
                    end else if (age_q[v] < sel_age) begin
                        age_d[v] = age_q[v] + AGEW'(1);
                    end
                end
                steal_d = !free_valid;
            end else begin
                for (int unsigned v = 0; v < NVOICES; v++) begin
                    if (gate_q[v] && (vkey_q[v] == ev_idx)) gate_d[v] = 1'b0;
                end
            end
        end
        count_d = '0;
        for (int unsigned v = 0; v < NVOICES; v++) begin
            count_d = count_d + CNTW'(gate_d[v]);
        end
        if (count_d > CNTW'(NVOICES)) count_d = CNTW'(NVOICES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_q <= '0;
            gate_q      <= '0;
            retrig_q    <= '0;
            count_q     <= '0;
            steal_q     <= 1'b0;
            for (int unsigned v = 0; v < NVOICES; v++) begin
                vkey_q[v] <= '0;
                age_q[v]  <= AGEW'(v);
            end
        end else begin
            key_state_q <= key_state_d;
            gate_q      <= gate_d;
            retrig_q    <= retrig_d;
            count_q     <= count_d;
            steal_q     <= steal_d;
            vkey_q      <= vkey_d;
            age_q       <= age_d;
        end
    end

    assign voice_gate   = gate_q;
    assign voice_retrig = retrig_q;
    assign voice_count  = count_q;
    assign steal        = steal_q;

    always_comb begin
        voice_key = '0;
        for (int unsigned v = 0; v < NVOICES; v++) begin
            voice_key[vk_lsb(v) +: KEYW] = vkey_q[v];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: fixed vector table, directed corner sequences, and
// randomized key activity checked against an LRU-list reference model.
module tb_voice_allocator;
    import audio_pkg::*;

    localparam int NV = 4;
    localparam int NK = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NK-1:0]     key;
    logic [NV-1:0]     voice_gate;
    logic [NV*KEYW-1:0] voice_key;
    logic [NV-1:0]     voice_retrig;
    logic [3:0]        voice_count;
    logic              steal;

    voice_allocator #(.NVOICES(NV), .NKEYS(NK)) dut (
        .clk(clk), .rst(rst), .key(key),
        .voice_gate(voice_gate), .voice_key(voice_key), .voice_retrig(voice_retrig),
        .voice_count(voice_count), .steal(steal)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: voice recency kept as a list, most recent first.
    bit [NK-1:0] m_ks;
    bit          m_g [NV];
    int          m_k [NV];
    int          lru [$];
    bit [NV-1:0] m_retrig;
    bit          m_steal;

    function automatic void model_reset();
        m_ks = '0;
        lru  = {};
        for (int v = 0; v < NV; v++) begin
            m_g[v] = 1'b0;
            m_k[v] = 0;
            lru.push_back(v);
        end
        m_retrig = '0;
        m_steal  = 1'b0;
    endfunction

    function automatic void model_step(input bit [NK-1:0] k);
        int ev = -1;
        int v = -1;
        int pos = -1;
        m_retrig = '0;
        m_steal  = 1'b0;
        for (int i = 0; i < NK; i++) if (ev < 0 && k[i] != m_ks[i]) ev = i;
        if (ev < 0) return;
        m_ks[ev] = k[ev];
        if (k[ev]) begin
            for (int i = 0; i < NV; i++) if (v < 0 && !m_g[i] && m_k[i] == ev) v = i;
            for (int i = 0; i < NV; i++) if (v < 0 && !m_g[i]) v = i;
            if (v < 0) begin
                v = lru[$];
                m_steal = 1'b1;
            end
            m_g[v] = 1'b1;
            m_k[v] = ev;
            m_retrig[v] = 1'b1;
            for (int p = 0; p < lru.size(); p++) if (lru[p] == v) pos = p;
            lru.delete(pos);
            lru.push_front(v);
        end else begin
            for (int i = 0; i < NV; i++) if (m_g[i] && m_k[i] == ev) m_g[i] = 1'b0;
        end
    endfunction

    function automatic logic [NV-1:0] m_gate_vec();
        logic [NV-1:0] g;
        for (int v = 0; v < NV; v++) g[v] = m_g[v];
        return g;
    endfunction

    function automatic logic [NV*KEYW-1:0] m_vkey_vec();
        logic [NV*KEYW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*KEYW +: KEYW] = KEYW'(m_k[v]);
        return r;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int v = 0; v < NV; v++) c += int'(m_g[v]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".gate"},   32'(voice_gate),   32'(m_gate_vec()));
        chk({tag, ".vkey"},   32'(voice_key),    32'(m_vkey_vec()));
        chk({tag, ".retrig"}, 32'(voice_retrig), 32'(m_retrig));
        chk({tag, ".count"},  32'(voice_count),  32'(m_count()));
        chk({tag, ".steal"},  32'(steal),        32'(m_steal));
    endtask

    task automatic tick(input logic [NK-1:0] k, input string tag);
        key = k;
        @(posedge clk);
        model_step(k);
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".gate"},   32'(voice_gate),   32'h0);
        chk({tag, ".vkey"},   32'(voice_key),    32'h0);
        chk({tag, ".retrig"}, 32'(voice_retrig), 32'h0);
        chk({tag, ".count"},  32'(voice_count),  32'h0);
        chk({tag, ".steal"},  32'(steal),        32'h0);
    endtask

    task automatic do_reset();
        key = '0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst");
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NK-1:0]      k;
        logic [NV-1:0]      g;
        logic [NV*KEYW-1:0] vk;
        logic [NV-1:0]      rt;
        logic [3:0]         cnt;
        logic               st;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [NK-1:0] k;

        tbl[0] = '{8'h01, 4'b0001, 12'h000, 4'b0001, 4'd1, 1'b0};
        tbl[1] = '{8'h0F, 4'b0011, 12'h008, 4'b0010, 4'd2, 1'b0};
        tbl[2] = '{8'h0F, 4'b0111, 12'h088, 4'b0100, 4'd3, 1'b0};
        tbl[3] = '{8'h0F, 4'b1111, 12'h688, 4'b1000, 4'd4, 1'b0};
        tbl[4] = '{8'h1F, 4'b1111, 12'h68C, 4'b0001, 4'd4, 1'b1};
        tbl[5] = '{8'h1E, 4'b1111, 12'h68C, 4'b0000, 4'd4, 1'b0};
        tbl[6] = '{8'h1E, 4'b1111, 12'h68C, 4'b0000, 4'd4, 1'b0};

        key = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("init");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].k, "tblm");
            chk("tbl.gate",   32'(voice_gate),   32'(tbl[i].g));
            chk("tbl.vkey",   32'(voice_key),    32'(tbl[i].vk));
            chk("tbl.retrig", 32'(voice_retrig), 32'(tbl[i].rt));
            chk("tbl.count",  32'(voice_count),  32'(tbl[i].cnt));
            chk("tbl.steal",  32'(steal),        32'(tbl[i].st));
        end

        // Idle voice still holding key 2 is reused ahead of lower free voice 1
        do_reset();
        tick(8'h01, "reuse");
        tick(8'h03, "reuse");
        tick(8'h07, "reuse");
        tick(8'h03, "reuse");
        tick(8'h02, "reuse");
        tick(8'h22, "reuse");
        tick(8'h20, "reuse");
        tick(8'h24, "reuse");
        chk("reuse.retrig", 32'(voice_retrig), 32'b0100);

        // Key 3 pulses for one cycle behind pending keys 0..2
        do_reset();
        tick(8'h0F, "pulse");
        tick(8'h07, "pulse");
        tick(8'h07, "pulse");
        tick(8'h07, "pulse");
        tick(8'h07, "pulse");
        chk("pulse.gate",  32'(voice_gate),  32'b0111);
        chk("pulse.count", 32'(voice_count), 32'd3);
        chk("pulse.vkey",  32'(voice_key),   32'h088);

        // Asynchronous reset mid-cycle with keys held, then reallocation
        #2;
        rst = 1'b1;
        #1;
        check_zero("arst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(8'h07, "rearm");
        chk("rearm0.retrig", 32'(voice_retrig), 32'b0001);
        tick(8'h07, "rearm");
        chk("rearm1.retrig", 32'(voice_retrig), 32'b0010);
        tick(8'h07, "rearm");
        chk("rearm2.retrig", 32'(voice_retrig), 32'b0100);
        chk("rearm.vkey",    32'(voice_key),    32'h088);

        do_reset();
        k = '0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 4) == 0) k = NK'($urandom);
            else if ($urandom_range(0, 2) != 0) k[$urandom_range(0, NK - 1)] ^= 1'b1;
            tick(k, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NVOICES, default 4: number of oscillator/envelope voices managed (2..8).
REQ-002 Parameter NKEYS, default 8: number of key inputs; KEYW = 3 is the key index width.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 key  input  NKEYS  key levels, 1 = held; synchronous to clk (debounced upstream, active-high).
REQ-006 voice_gate  output  NVOICES  per-voice envelope gate, 1 = note on.
REQ-007 voice_key  output  NVOICES*KEYW  flat vector of per-voice key index; voice v occupies bits [v*KEYW +: KEYW].
REQ-008 voice_retrig  output  NVOICES  1-cycle pulse on the voice just (re)assigned by a press.
REQ-009 voice_count  output  4  number of voices with gate = 1.
REQ-010 steal  output  1  1-cycle pulse when a press takes a gated voice.

Function
REQ-011 Keep a registered key_state[NKEYS]; a key event exists for key i when key[i] != key_state[i].
REQ-012 Process exactly one event per cycle: the lowest index i with an event; set key_state[i] <= key[i] on that edge.
REQ-013 A key that toggles and returns before it is serviced generates no event and no output change.
REQ-014 Latency: an uncontested event updates outputs on the first rising edge after key changes; the Nth pending event is serviced on edge N.
REQ-015 Press of key k selects a voice by priority: (a) a voice with voice_key = k and gate = 0; (b) the lowest-index voice with gate = 0; (c) the oldest voice (age = NVOICES-1).
REQ-016 On press: selected voice gets gate <= 1, voice_key <= k, voice_retrig pulse; steal pulses only in case (c).
REQ-017 A key already owned by a gated voice cannot be pressed again, because key_state prevents a second press event.
REQ-018 Ages form a permutation of 0..NVOICES-1; on allocation of voice v with age a, every voice with age < a increments and v becomes 0. Ages are unchanged otherwise.
REQ-019 Release of key k: every voice with gate = 1 and voice_key = k gets gate <= 0; voice_key and age are retained.
REQ-020 Release of a key that owns no gated voice (voice was stolen) changes no output.
REQ-021 voice_retrig and steal are 0 on all cycles without a servicing press.
REQ-022 voice_count is registered, consistent with voice_gate on the same cycle, and saturates at NVOICES.

Reset
REQ-023 While rst = 1: key_state = 0, voice_gate = 0, voice_key = 0 for all voices, voice_retrig = 0, steal = 0, voice_count = 0, age[v] = v.
REQ-024 Reset asserted mid-operation clears all state immediately; keys still held at deassertion are seen as new presses and serviced per REQ-012.

Structure
REQ-025 Shared package audio_pkg holds NVOICES default, NKEYS default, KEYW, and the voice_key slice helper constants; the package is shared with the oscillator/envelope top.
REQ-026 One sub-module, lowest_set: a parameterised combinational lowest-set-bit encoder that returns index and a valid flag. It is used for event selection and free-voice selection.
REQ-027 The allocation decision is combinational from registered state; all outputs are registered; there are no other sub-modules.

Verification
REQ-028 Reset, then key = 8'h01 -> after 1 edge, voice_gate = 4'b0001, voice_key[0] = 0, voice_retrig = 4'b0001, voice_count = 1.
REQ-029 Set key = 8'h0F in one cycle -> voices 0..3 are gated with keys 0,1,2,3 on edges 1..4 in order; one retrig per edge; voice_count = 4; steal is never asserted.
REQ-030 From REQ-029, press key 4 -> voice 0 (oldest) is reassigned to key 4, steal = 1, retrig = 4'b0001, voice_count = 4. Releasing key 0 afterwards changes nothing.
REQ-031 Press key 2, release it, press key 5, then press key 2 again -> the second press of key 2 reuses the voice that still holds voice_key = 2 (case (a)), not the lowest free voice.
REQ-032 Pulse key 3 high for 1 cycle while 3 lower-index events are pending -> no event is ever generated for key 3.
REQ-033 Assert rst while 3 voices are gated and keys are held -> all outputs are 0 asynchronously; after deassertion the held keys are reallocated lowest index first, 1 per edge.
